// File: rtl/sram_burst_master_pkg.sv
// Shared definitions for the SRAM line burst master and its callers:
// default geometry and the controller state encoding.
package sram_burst_master_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_DATA_DEPTH = 1024;
  localparam int DEF_BURST_LEN  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

endpackage

// File: rtl/sram_burst_master_if.sv
// Line-request, write/read beat streams and single-port SRAM pins of the burst master.
// The master modport is the burst master's view; slave is the surrounding logic's view.
interface sram_burst_master_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;

  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_last;

  logic                  wr_done;

  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  sram_ce;
  logic                  sram_we;
  logic [DATA_WIDTH-1:0] sram_dataw;
  logic [DATA_WIDTH-1:0] sram_datar;

  modport master (
    input  req_valid, req_write, req_addr,
    output req_ready,
    input  wdata_valid, wdata,
    output wdata_ready,
    output rdata_valid, rdata, rdata_last,
    input  rdata_ready,
    output wr_done,
    output sram_addr, sram_ce, sram_we, sram_dataw,
    input  sram_datar
  );

  modport slave (
    output req_valid, req_write, req_addr,
    input  req_ready,
    output wdata_valid, wdata,
    input  wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    output rdata_ready,
    input  wr_done,
    input  sram_addr, sram_ce, sram_we, sram_dataw,
    output sram_datar
  );

endinterface

// File: rtl/sram_burst_master.sv
// Splits line requests into BURST_LEN single-beat SRAM accesses; writes land the cycle they handshake,
// read beats are registered once (first beat one cycle after entering READ) and stall under rdata_ready.
module sram_burst_master
  import sram_burst_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  sram_burst_master_if.master bus
);

  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int CNT_WIDTH  = $clog2(BURST_LEN);

  localparam logic [CNT_WIDTH:0]    LAST_BEAT  = (CNT_WIDTH+1)'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH:0]    ALL_BEATS  = (CNT_WIDTH+1)'(BURST_LEN);
  localparam logic [CNT_WIDTH:0]    CNT_ONE    = (CNT_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BURST_LEN - 1));

  state_t                state_q;
  state_t                state_d;

  // One extra bit so READ can tell "all beats issued" apart from beat 0.
  logic [CNT_WIDTH:0]    cnt_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;
  logic                  rdata_last_q;
  logic                  wr_done_q;

  logic                  req_ready;
  logic                  wdata_ready;
  logic                  rd_issue;
  logic                  req_fire;
  logic                  wr_beat;
  logic                  wr_last;
  logic                  rd_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          state_d = bus.req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; everything is held quiet while rst is high so an aborted burst touches nothing more.
  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rd_issue    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE:  req_ready   = 1'b1;
        ST_WRITE: wdata_ready = 1'b1;
        ST_READ:  rd_issue    = (cnt_q < ALL_BEATS) && (!rdata_valid_q || bus.rdata_ready);
        default:  ;
      endcase
    end
  end

  assign req_fire = req_ready && bus.req_valid;
  assign wr_beat  = wdata_ready && bus.wdata_valid;
  assign wr_last  = wr_beat && (cnt_q == LAST_BEAT);
  assign rd_done  = (state_q == ST_READ) && rdata_valid_q && bus.rdata_ready && rdata_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      wr_done_q <= wr_last;

      if (req_fire) begin
        cnt_q <= '0;
      end else if (wr_beat || rd_issue) begin
        cnt_q <= cnt_q + CNT_ONE;
      end

      if (rd_issue) begin
        rdata_valid_q <= 1'b1;
        rdata_last_q  <= (cnt_q == LAST_BEAT);
      end else if (bus.rdata_ready) begin
        rdata_valid_q <= 1'b0;
      end
    end
  end

  // Datapath registers carry no reset: base is reloaded on every request, rdata is qualified by valid.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      base_q <= bus.req_addr & ALIGN_MASK;
    end
    if (rd_issue) begin
      rdata_q <= bus.sram_datar;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.wdata_ready = wdata_ready;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_last  = rdata_last_q;
  assign bus.wr_done     = wr_done_q;

  // Beat index is OR'ed into the aligned base, so a burst can never carry into the next line.
  assign bus.sram_addr   = base_q | {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, cnt_q[CNT_WIDTH-1:0]};
  assign bus.sram_ce     = wr_beat || rd_issue;
  assign bus.sram_we     = wr_beat;
  assign bus.sram_dataw  = bus.wdata;

endmodule

// File: tb/tb_sram_burst_master.sv
// Bench for sram_burst_master with an async-read SRAM model and a line-level reference memory.
module tb_sram_burst_master;

  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int BL    = 8;
  localparam int AW    = 10;

  logic clk;
  logic rst;

  int passed = 0;
  int total  = 0;

  sram_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_burst_master #(
    .DATA_WIDTH(DW),
    .DATA_DEPTH(DEPTH),
    .BURST_LEN (BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // SRAM seen by the DUT, and the bench's own expectation of its contents.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  assign bus.sram_datar = mem[bus.sram_addr];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = {32'h5A5A0000, 22'h0, i[9:0]};
    end
    forever begin
      @(posedge clk);
      if (bus.sram_ce && bus.sram_we) begin
        mem[bus.sram_addr] <= bus.sram_dataw;
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_req(input logic [AW-1:0] a, input bit w);
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_addr    = a;
    bus.wdata_valid = 1'b0;
    bus.rdata_ready = 1'b0;
    #1;
    chk("req_ready_idle", bus.req_ready, 1);
    chk("idle_no_access", bus.sram_ce, 0);
  endtask

  task automatic write_line(input logic [AW-1:0] a, input logic [DW-1:0] d0, input bit gaps,
                            output logic [AW-1:0] first_a, output logic [AW-1:0] last_a);
    logic [AW-1:0] base;
    int k;
    int c;
    bit v;
    base    = a & 10'h3F8;
    first_a = '0;
    last_a  = '0;
    k = 0;
    c = 0;
    send_req(a, 1'b1);
    while (k < BL && c < 200) begin
      @(negedge clk);
      c++;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.req_valid   = 1'b0;
      bus.wdata_valid = v;
      bus.wdata       = d0 + 64'(k);
      bus.rdata_ready = 1'($urandom_range(0, 1));
      #1;
      chk("wr_wdata_ready", bus.wdata_ready, 1);
      chk("wr_req_ready", bus.req_ready, 0);
      chk("wr_done_early", bus.wr_done, 0);
      chk("wr_ce", bus.sram_ce, v);
      chk("wr_we", bus.sram_we, v);
      if (v) begin
        chk("wr_addr", bus.sram_addr, base + AW'(k));
        chk("wr_dataw", bus.sram_dataw, d0 + 64'(k));
        if (k == 0) first_a = bus.sram_addr;
        last_a = bus.sram_addr;
        ref_mem[base + AW'(k)] = d0 + 64'(k);
        k++;
      end
    end
    chk("wr_beats_done", k, BL);
    if (!gaps) chk("wr_consecutive", c, BL);
    @(negedge clk);
    bus.wdata_valid = 1'b0;
    #1;
    chk("wr_done_pulse", bus.wr_done, 1);
    chk("wr_req_ready_back", bus.req_ready, 1);
    @(negedge clk);
    #1;
    chk("wr_done_once", bus.wr_done, 0);
  endtask

  // rmode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating, 2 = random ready.
  task automatic read_beats(input logic [AW-1:0] base, input int rmode, input bit hold_req);
    int k;
    int c;
    int first_c;
    int last_c;
    bit stalled;
    logic [DW-1:0] held;
    logic held_last;
    k = 0;
    c = 0;
    first_c = -1;
    last_c = -1;
    stalled = 1'b0;
    held = '0;
    held_last = 1'b0;
    while (k < BL && c < 200) begin
      @(negedge clk);
      c++;
      bus.req_valid   = hold_req;
      bus.wdata_valid = 1'($urandom_range(0, 1));
      case (rmode)
        0:       bus.rdata_ready = 1'b1;
        1:       bus.rdata_ready = ((c - 1) % 3 == 0);
        default: bus.rdata_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("rd_wdata_ready", bus.wdata_ready, 0);
      chk("rd_no_write", bus.sram_we, 0);
      if (hold_req) chk("rd_req_ignored", bus.req_ready, 0);
      if (stalled && bus.rdata_valid) begin
        chk("rd_stall_data", bus.rdata, held);
        chk("rd_stall_last", bus.rdata_last, held_last);
      end
      if (bus.rdata_valid && !bus.rdata_ready) chk("rd_stall_ce", bus.sram_ce, 0);
      if (bus.rdata_valid && bus.rdata_ready) begin
        chk("rd_data", bus.rdata, ref_mem[base + AW'(k)]);
        chk("rd_last", bus.rdata_last, (k == BL - 1));
        if (first_c < 0) first_c = c;
        last_c = c;
        k++;
      end
      stalled   = bus.rdata_valid && !bus.rdata_ready;
      held      = bus.rdata;
      held_last = bus.rdata_last;
    end
    chk("rd_beats_done", k, BL);
    if (rmode == 0) begin
      chk("rd_first_beat_cycle", first_c, 2);
      chk("rd_last_beat_cycle", last_c, BL + 1);
    end
    @(negedge clk);
    bus.req_valid   = hold_req;
    bus.rdata_ready = 1'b0;
    bus.wdata_valid = 1'b0;
    #1;
    chk("rd_req_ready_back", bus.req_ready, 1);
    chk("rd_valid_cleared", bus.rdata_valid, 0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    bit            gaps;
    logic [DW-1:0] d0;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } wvec_t;

  wvec_t vecs [4];

  initial begin
    logic [AW-1:0] fa;
    logic [AW-1:0] la;
    logic [AW-1:0] ra;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = {32'h5A5A0000, 22'h0, i[9:0]};
    end
    vecs[0] = '{10'h013, 1'b0, 64'h00000000000000A0, 10'h010, 10'h017};
    vecs[1] = '{10'h3FF, 1'b1, 64'hC0FFEE0000000000, 10'h3F8, 10'h3FF};
    vecs[2] = '{10'h2A5, 1'b1, 64'h1234567800000000, 10'h2A0, 10'h2A7};
    vecs[3] = '{10'h005, 1'b0, 64'hFFFFFFFFFFFFFFFC, 10'h000, 10'h007};

    rst = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b0;

    repeat (2) @(negedge clk);
    bus.wdata_valid = 1'b1;
    bus.req_valid   = 1'b1;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_wdata_ready", bus.wdata_ready, 0);
    chk("rst_ce", bus.sram_ce, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.wdata_valid = 1'b0;
    bus.req_valid   = 1'b0;
    #1;
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rdata_valid", bus.rdata_valid, 0);
    chk("reset_rdata_last", bus.rdata_last, 0);
    chk("reset_wr_done", bus.wr_done, 0);
    chk("reset_ce", bus.sram_ce, 0);
    chk("reset_we", bus.sram_we, 0);

    // Line writes with address alignment and the last-line boundary
    for (int i = 0; i < 4; i++) begin
      write_line(vecs[i].addr, vecs[i].d0, vecs[i].gaps, fa, la);
      chk("vec_first_addr", fa, vecs[i].exp_first);
      chk("vec_last_addr", la, vecs[i].exp_last);
    end
    chk("last_line_no_wrap", mem[10'h000], 64'hFFFFFFFFFFFFFFFC);

    // Read back line 0x010 at full rate, then with 1,0,0 backpressure
    send_req(10'h010, 1'b0);
    read_beats(10'h010, 0, 1'b0);
    chk("rd_line_word0", mem[10'h010], 64'hA0);
    chk("rd_line_word7", mem[10'h017], 64'hA7);
    send_req(10'h017, 1'b0);
    read_beats(10'h010, 1, 1'b0);

    // req_valid held through a read burst is picked up only after it completes
    send_req(10'h3FA, 1'b0);
    read_beats(10'h3F8, 2, 1'b1);
    read_beats(10'h3F8, 0, 1'b0);

    // Reset after three write beats leaves a partial line and no wr_done
    send_req(10'h010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid   = 1'b0;
      bus.wdata_valid = 1'b1;
      bus.wdata       = 64'hB0 + 64'(k);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.wdata = 64'hB3;
    #1;
    chk("rst_wr_no_access", bus.sram_ce, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.wdata_valid = 1'b0;
    #1;
    chk("rst_wr_idle", bus.req_ready, 1);
    chk("rst_wr_no_done", bus.wr_done, 0);
    @(negedge clk);
    #1;
    chk("rst_wr_no_done_late", bus.wr_done, 0);
    for (int i = 0; i < BL; i++) begin
      chk("rst_wr_mem", mem[10'h010 + AW'(i)], (i < 3) ? 64'hB0 + 64'(i) : 64'hA0 + 64'(i));
      if (i < 3) ref_mem[10'h010 + AW'(i)] = 64'hB0 + 64'(i);
    end

    // Reset while a read beat is stalled drops the beat
    send_req(10'h2A0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      bus.req_valid   = 1'b0;
      bus.rdata_ready = 1'b0;
    end
    #1;
    chk("rst_rd_pending", bus.rdata_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rd_no_access", bus.sram_ce, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rd_dropped", bus.rdata_valid, 0);
    chk("rst_rd_idle", bus.req_ready, 1);

    // Randomized line traffic against the reference memory
    for (int n = 0; n < 30; n++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        write_line(ra, {$urandom, $urandom}, 1'b1, fa, la);
        chk("rnd_wr_first", fa, ra & 10'h3F8);
        chk("rnd_wr_last", la, ra | 10'h007);
      end else begin
        send_req(ra, 1'b0);
        read_beats(ra & 10'h3F8, 2, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
